// File: rtl/w_loader.sv
// w_loader: weight-fetch stage between the weight buffer and the systolic
// array's shadow weight registers. An accepted clr_w starts a tile. The block
// then reads ROWS consecutive buffer rows from base_addr, one per w_read cycle,
// and shifts each returned row into the shadow chain one cycle after its read.
// w_done is raised once all ROWS rows have been shifted.
module w_loader #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 8,
  parameter int AW   = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_read,
  input  logic                     clr_w,
  input  logic [AW-1:0]            base_addr,
  output logic                     mem_rd_en,
  output logic [AW-1:0]            mem_addr,
  input  logic [COLS*DW-1:0]       mem_rdata,
  output logic                     w_shift,
  output logic [COLS*DW-1:0]       w_data,
  output logic [$clog2(ROWS)-1:0]  w_row,
  output logic                     w_done
);

  // Counters must be able to hold ROWS itself, not just ROWS-1.
  localparam int            CW     = $clog2(ROWS + 1);
  localparam int            RW     = $clog2(ROWS);
  localparam logic [CW-1:0] ROWS_C = CW'(ROWS);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   iss_q, iss_d;
  logic [CW-1:0]   rcv_q, rcv_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            vld_q, vld_d;
  logic            done_q, done_d;
  logic            start;
  logic            issue;

  // clr_w is only meaningful together with w_read. Reads are issued only
  // while fetching and while rows remain. Once in DONE, late w_read pulses
  // from the controller therefore do nothing.
  assign start = clr_w & w_read;
  assign issue = (state_q == FETCH) && w_read && (iss_q < ROWS_C);

  // Next-state logic: issue and receive bookkeeping. A start overrides
  // everything and discards the beat that is still in flight.
  always_comb begin
    state_d = state_q;
    iss_d   = iss_q;
    rcv_d   = rcv_q;
    addr_d  = addr_q;
    vld_d   = issue;
    done_d  = done_q;

    if (issue) begin
      iss_d  = iss_q + CW'(1);
      addr_d = addr_q + AW'(1);   // wraps modulo 2^AW
    end

    if (state_q == FETCH && vld_q) begin
      rcv_d = rcv_q + CW'(1);
      if (rcv_d == ROWS_C) begin
        state_d = DONE;
        done_d  = 1'b1;
      end
    end

    if (start) begin
      state_d = FETCH;
      iss_d   = '0;
      rcv_d   = '0;
      addr_d  = base_addr;
      vld_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  // State register with asynchronous reset; reset abandons any tile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      iss_q   <= '0;
      rcv_q   <= '0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iss_q   <= iss_d;
      rcv_q   <= rcv_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  assign mem_rd_en = issue;
  assign mem_addr  = addr_q;
  assign w_shift   = vld_q;
  assign w_row     = rcv_q[RW-1:0];
  assign w_done    = done_q;

  // Buffer data arrives the cycle after the read, which is the same cycle the
  // valid pipe raises w_shift. Each lane is passed through only while
  // shifting, so w_data stays 0 otherwise, including during reset.
  for (genvar gi = 0; gi < COLS; gi++) begin : g_lane
    assign w_data[gi*DW +: DW] = vld_q ? mem_rdata[gi*DW +: DW] : '0;
  end

endmodule

// File: tb/tb_w_loader.sv
// Bench for w_loader: per-cycle vector tables and a hand-written
// asynchronous-reset sequence.
module tb_w_loader;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 8;
  localparam int AW   = 10;

  logic                clk;
  logic                rst;
  logic                w_read;
  logic                clr_w;
  logic [AW-1:0]       base_addr;
  logic                mem_rd_en;
  logic [AW-1:0]       mem_addr;
  logic [COLS*DW-1:0]  mem_rdata;
  logic                w_shift;
  logic [COLS*DW-1:0]  w_data;
  logic [1:0]          w_row;
  logic                w_done;

  int checks = 0;
  int errors = 0;

  w_loader #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .w_read    (w_read),
    .clr_w     (clr_w),
    .base_addr (base_addr),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .w_shift   (w_shift),
    .w_data    (w_data),
    .w_row     (w_row),
    .w_done    (w_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer contents are a fixed function of the address.
  function automatic logic [COLS*DW-1:0] buf_word(input logic [AW-1:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return {lo ^ 8'h5A, ~lo, lo + 8'd3, {6'd0, a[9:8]} ^ 8'hC3};
  endfunction

  // Buffer model: registered read, data valid the cycle after mem_rd_en.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= buf_word(mem_addr);
  end

  typedef struct {
    logic          wr;
    logic          clr;
    logic [AW-1:0] base;
    logic          rd;
    logic [AW-1:0] addr;
    logic          sh;
    logic [1:0]    row;
    logic [AW-1:0] daddr;
    logic          done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic wr, input logic clr, input logic [AW-1:0] base,
                              input logic rd, input logic [AW-1:0] addr,
                              input logic sh, input logic [1:0] row,
                              input logic [AW-1:0] daddr, input logic done);
    vec_t v;
    v.wr = wr; v.clr = clr; v.base = base; v.rd = rd; v.addr = addr;
    v.sh = sh; v.row = row; v.daddr = daddr; v.done = done;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One vector per cycle: inputs applied 1 time unit after the rising edge,
  // outputs sampled 1 unit later, both well before the falling edge.
  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      w_read    = tbl[i].wr;
      clr_w     = tbl[i].clr;
      base_addr = tbl[i].base;
      #1;
      chk($sformatf("%s c%0d mem_rd_en", name, i), 64'(mem_rd_en), 64'(tbl[i].rd));
      if (tbl[i].rd)
        chk($sformatf("%s c%0d mem_addr", name, i), 64'(mem_addr), 64'(tbl[i].addr));
      chk($sformatf("%s c%0d w_shift", name, i), 64'(w_shift), 64'(tbl[i].sh));
      if (tbl[i].sh) begin
        chk($sformatf("%s c%0d w_row", name, i), 64'(w_row), 64'(tbl[i].row));
        chk($sformatf("%s c%0d w_data", name, i), 64'(w_data), 64'(buf_word(tbl[i].daddr)));
      end
      chk($sformatf("%s c%0d w_done", name, i), 64'(w_done), 64'(tbl[i].done));
      $display("[%s c%0d] w_read=%b clr_w=%b rd_en=%b addr=%03h shift=%b row=%0d data=%08h done=%b",
               name, i, w_read, clr_w, mem_rd_en, mem_addr, w_shift, w_row, w_data, w_done);
    end
    tbl.delete();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " mem_rd_en"}, 64'(mem_rd_en), 64'd0);
    chk({name, " mem_addr"},  64'(mem_addr),  64'd0);
    chk({name, " w_shift"},   64'(w_shift),   64'd0);
    chk({name, " w_data"},    64'(w_data),    64'd0);
    chk({name, " w_row"},     64'(w_row),     64'd0);
    chk({name, " w_done"},    64'(w_done),    64'd0);
    $display("[%s] rd_en=%b addr=%03h shift=%b data=%08h row=%0d done=%b",
             name, mem_rd_en, mem_addr, w_shift, w_data, w_row, w_done);
  endtask

  localparam logic [AW-1:0] J = 10'h2AA;  // junk base_addr when clr_w is low

  initial begin
    rst = 1'b1; w_read = 1'b1; clr_w = 1'b1; base_addr = 10'h155;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    #2;
    chk_all_zero("reset");
    #1;
    w_read = 1'b0; clr_w = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Nominal load from IDLE, then late w_read pulses after w_done.
    tbl.push_back(mk(1, 1, 10'h010, 0, 0,       0, 0, 0,       0));
    tbl.push_back(mk(1, 0, J,       1, 10'h010, 0, 0, 0,       0));
    tbl.push_back(mk(1, 0, J,       1, 10'h011, 1, 0, 10'h010, 0));
    tbl.push_back(mk(1, 0, J,       1, 10'h012, 1, 1, 10'h011, 0));
    tbl.push_back(mk(1, 0, J,       1, 10'h013, 1, 2, 10'h012, 0));
    tbl.push_back(mk(1, 0, J,       0, 0,       1, 3, 10'h013, 0));
    tbl.push_back(mk(1, 0, J,       0, 0,       0, 0, 0,       1));
    tbl.push_back(mk(1, 0, J,       0, 0,       0, 0, 0,       1));
    tbl.push_back(mk(1, 0, J,       0, 0,       0, 0, 0,       1));
    tbl.push_back(mk(1, 0, J,       0, 0,       0, 0, 0,       1));
    run_table("nominal");

    // Restart from DONE with a 2-cycle stall after the second issue.
    tbl.push_back(mk(1, 1, 10'h010, 0, 0,       0, 0, 0,       1));
    tbl.push_back(mk(1, 0, J,       1, 10'h010, 0, 0, 0,       0));
    tbl.push_back(mk(1, 0, J,       1, 10'h011, 1, 0, 10'h010, 0));
    tbl.push_back(mk(0, 0, J,       0, 0,       1, 1, 10'h011, 0));
    tbl.push_back(mk(0, 0, J,       0, 0,       0, 0, 0,       0));
    tbl.push_back(mk(1, 0, J,       1, 10'h012, 0, 0, 0,       0));
    tbl.push_back(mk(1, 0, J,       1, 10'h013, 1, 2, 10'h012, 0));
    tbl.push_back(mk(1, 0, J,       0, 0,       1, 3, 10'h013, 0));
    tbl.push_back(mk(1, 0, J,       0, 0,       0, 0, 0,       1));
    run_table("stall");

    // Address wrap past 2^AW-1.
    tbl.push_back(mk(1, 1, 10'h3FE, 0, 0,       0, 0, 0,       1));
    tbl.push_back(mk(1, 0, J,       1, 10'h3FE, 0, 0, 0,       0));
    tbl.push_back(mk(1, 0, J,       1, 10'h3FF, 1, 0, 10'h3FE, 0));
    tbl.push_back(mk(1, 0, J,       1, 10'h000, 1, 1, 10'h3FF, 0));
    tbl.push_back(mk(1, 0, J,       1, 10'h001, 1, 2, 10'h000, 0));
    tbl.push_back(mk(1, 0, J,       0, 0,       1, 3, 10'h001, 0));
    tbl.push_back(mk(1, 0, J,       0, 0,       0, 0, 0,       1));
    run_table("wrap");

    // Restart mid-tile coinciding with a shift: the shift completes, the
    // beat read in the restart cycle is dropped, and the new tile follows.
    tbl.push_back(mk(1, 1, 10'h020, 0, 0,       0, 0, 0,       1));
    tbl.push_back(mk(1, 0, J,       1, 10'h020, 0, 0, 0,       0));
    tbl.push_back(mk(1, 0, J,       1, 10'h021, 1, 0, 10'h020, 0));
    tbl.push_back(mk(1, 1, 10'h100, 1, 10'h022, 1, 1, 10'h021, 0));
    tbl.push_back(mk(1, 0, J,       1, 10'h100, 0, 0, 0,       0));
    tbl.push_back(mk(1, 0, J,       1, 10'h101, 1, 0, 10'h100, 0));
    tbl.push_back(mk(1, 0, J,       1, 10'h102, 1, 1, 10'h101, 0));
    tbl.push_back(mk(1, 0, J,       1, 10'h103, 1, 2, 10'h102, 0));
    tbl.push_back(mk(1, 0, J,       0, 0,       1, 3, 10'h103, 0));
    tbl.push_back(mk(1, 0, J,       0, 0,       0, 0, 0,       1));
    run_table("restart");

    // Asynchronous reset between edges in the middle of a fetch.
    tbl.push_back(mk(1, 1, 10'h040, 0, 0,       0, 0, 0,       1));
    tbl.push_back(mk(1, 0, J,       1, 10'h040, 0, 0, 0,       0));
    tbl.push_back(mk(1, 0, J,       1, 10'h041, 1, 0, 10'h040, 0));
    run_table("pre_rst");
    #1;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 0, J, 0, 0, 0, 0, 0, 0));
    run_table("post_rst");

    // Fresh tile from IDLE after reset.
    tbl.push_back(mk(1, 1, 10'h3F0, 0, 0,       0, 0, 0,       0));
    tbl.push_back(mk(1, 0, J,       1, 10'h3F0, 0, 0, 0,       0));
    tbl.push_back(mk(1, 0, J,       1, 10'h3F1, 1, 0, 10'h3F0, 0));
    tbl.push_back(mk(1, 0, J,       1, 10'h3F2, 1, 1, 10'h3F1, 0));
    tbl.push_back(mk(1, 0, J,       1, 10'h3F3, 1, 2, 10'h3F2, 0));
    tbl.push_back(mk(1, 0, J,       0, 0,       1, 3, 10'h3F3, 0));
    tbl.push_back(mk(0, 0, J,       0, 0,       0, 0, 0,       1));
    run_table("recover");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/w_loader.md
# w_loader

Weight-fetch stage that sits directly downstream of the weight controller's `w_read`/`clr_w` outputs and directly upstream of its `w_done` input. It reads ROWS weight rows from the on-chip weight buffer and streams them into the systolic array's shadow weight registers, one row per cycle. It raises `w_done` once the full tile is resident in the shadow registers, which lets the controller issue `switch`.

## Interface
- ROWS, default 4: weight rows per tile, equal to the array height; must be ≥2.
- COLS, default 4: PEs per row.
- DW, default 8: bits per weight.
- AW, default 10: weight-buffer address width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- w_read  in  1  fetch enable from the weight controller.
- clr_w  in  1  tile restart. Sampled only when w_read=1; ignored (may be X) otherwise.
- base_addr  in  AW  buffer address of row 0 of the tile. Sampled when clr_w & w_read.
- mem_rd_en  out  1  buffer read strobe.
- mem_addr  out  AW  buffer read address.
- mem_rdata  in  COLS*DW  buffer read data. Valid exactly 1 cycle after mem_rd_en.
- w_shift  out  1  shift enable for the shadow weight chain.
- w_data  out  COLS*DW  row data presented with w_shift.
- w_row  out  $clog2(ROWS)  index of the row currently on w_data.
- w_done  out  1  full tile loaded; stays high until the next accepted clr_w.

## Operation
- **State machine.** States are IDLE, FETCH and DONE.
  - IDLE→FETCH: on clr_w & w_read.
  - FETCH→DONE: when the received-row count reaches ROWS.
  - DONE→FETCH: on clr_w & w_read.
  - DONE otherwise holds.
- **Start.** On an accepted clr_w:
  - issue counter `iss` ← 0, receive counter `rcv` ← 0.
  - address register ← base_addr.
  - w_done ← 0.
  - in-flight beat discarded.
- **Issue (FETCH).** When w_read=1 and iss<ROWS:
  - mem_rd_en=1, mem_addr=addr.
  - next cycle: addr ← addr+1, iss ← iss+1.
  - When w_read=0: no issue, counters hold. An outstanding beat still returns and is shifted.
- **Receive.** A 1-bit valid pipe tracks each issued read.
  - One cycle after each issue: w_shift=1, w_data=mem_rdata, w_row=rcv, then rcv ← rcv+1.
  - Rows are shifted in order 0..ROWS-1.
- **Completion.** When rcv reaches ROWS, w_done is registered high. Further w_read pulses are ignored: no mem_rd_en, no w_shift. The controller's w_read lags w_done by one cycle, so this is required.
- **Address arithmetic.** Modulo 2^AW; base_addr+ROWS-1 may wrap past 2^AW-1 to 0.
- **Restart mid-tile.** clr_w & w_read in FETCH restarts immediately from the new base_addr. A beat issued in the previous cycle produces no w_shift. rcv/iss restart from 0.
- **Combinational outputs.** mem_rd_en and mem_addr are combinational from state/counters/w_read. All other outputs are registered.

## Timing
- **Reset.** While rst=1, and immediately on its assertion:
  - state=IDLE, iss=rcv=0, addr=0, valid pipe=0.
  - mem_rd_en=0, mem_addr=0, w_shift=0, w_data=0, w_row=0, w_done=0.
- **Reset mid-tile.** Abandons the tile; no w_shift after reset deasserts until a new clr_w.
- **Nominal sequence.** clr_w&w_read sampled at edge E0, with w_read held high:
  - mem_rd_en high in cycles E0+1 … E0+ROWS, at addresses base … base+ROWS-1.
  - w_shift high in cycles E0+2 … E0+ROWS+1.
  - w_done high from E0+ROWS+2.
  - Load latency is ROWS+2 cycles.
- **Stalls.** Each cycle with w_read=0 while iss<ROWS adds exactly one cycle to completion.
- **Restart in DONE.** clr_w & w_read while in DONE: w_done drops in the next cycle and mem_rd_en rises in that same cycle.
- **Shift/restart overlap.** w_shift and a new accepted clr_w in the same cycle: the shift completes, and the new tile's row 0 follows 2 cycles later.

## Test plan
- **Nominal load.** Reset, base_addr=0x010, ROWS=4, clr_w&w_read for 1 cycle, then w_read=1.
  - Reads at 0x010..0x013 in cycles 1–4.
  - w_shift in cycles 2–5 with w_row 0..3 and w_data equal to the buffer contents.
  - w_done=1 from cycle 6.
- **Stall.** Same as nominal, but w_read=0 for 2 cycles after the second issue.
  - Exactly 4 reads, no duplicates.
  - w_done delayed to cycle 8.
- **Wrap.** AW=10, base_addr=0x3FE → reads at 0x3FE, 0x3FF, 0x000, 0x001.
- **Late w_read.** After w_done, hold w_read=1 for 3 cycles → mem_rd_en=0, w_shift=0, w_done stays 1.
- **Restart mid-tile.** After 2 rows, apply clr_w&w_read with base_addr=0x100.
  - No shift of the in-flight old row.
  - Rows 0..3 from 0x100..0x103.
  - w_done after 4 more shifts.
- **Async reset.** Assert rst between clock edges during FETCH.
  - All outputs 0 before the next edge.
  - No further activity until a new clr_w.
